pre_i_gradient_gen: RTL and testbench



---
 rtl/pre_i_gradient_gen_pkg.sv | 27 ++
 rtl/pre_i_gradient_gen_if.sv | 30 +++
 rtl/pre_i_gradient_gen_sobel.sv | 27 ++
 rtl/pre_i_gradient_gen.sv | 190 +++++++++++++++++++
 tb/tb_pre_i_gradient_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pre_i_gradient_gen_pkg.sv
// Shared constants, widths and types for the pre-intra gradient generator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pre_i_pkg;

   localparam int SLOT_LEN  = 40;   // cycles per block slot
   localparam int NBLK      = 64;   // 8x8 blocks per CTU
   localparam int RUN_START = 2;    // first cnt with valid gradients
   localparam int NPOS      = 36;   // interior positions per 8x8 block

   localparam int CNT_W  = 6;
   localparam int BLK_W  = 7;
   localparam int GRAD_W = 11;
   localparam int ROW_W  = 64;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_LEN - 1);
   // The window for position i is read one cycle before it is shown.
   localparam logic [CNT_W-1:0] EMIT_FIRST = CNT_W'(RUN_START - 1);
   localparam logic [CNT_W-1:0] EMIT_LAST  = CNT_W'(RUN_START + NPOS - 2);
   localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(NBLK - 1);
   localparam logic [BLK_W-1:0] BLK_END    = BLK_W'(NBLK);

   typedef enum logic [1:0] {IDLE, WAIT, RUN, FLUSH} state_t;

   typedef logic signed [GRAD_W-1:0] grad_t;

endpackage

// File: rtl/pre_i_gradient_gen_if.sv
// Pixel-row load handshake plus the gradient/timing bus towards mode decision.
// Latency: none (wiring only).
// Backpressure: pix_ready gates pix_row; the gradient side has no backpressure.
interface pre_i_gradient_gen_if;
   import pre_i_pkg::*;

   logic               pix_valid;
   logic               pix_ready;
   logic [ROW_W-1:0]   pix_row;

   grad_t              gx;
   grad_t              gy;
   logic               counterrun1;
   logic               counterrun2;
   logic [CNT_W-1:0]   cnt;
   logic [BLK_W-1:0]   blockcnt;

   // Pixel source and gradient consumer.
   modport master (
      output pix_valid, pix_row,
      input  pix_ready, gx, gy, counterrun1, counterrun2, cnt, blockcnt
   );

   // Gradient generator.
   modport slave (
      input  pix_valid, pix_row,
      output pix_ready, gx, gy, counterrun1, counterrun2, cnt, blockcnt
   );

endinterface

// File: rtl/pre_i_gradient_gen_sobel.sv
// 3x3 Sobel gx/gy on a window of unsigned 8-bit pixels.
// Latency: combinational; the parent registers the results.
// Backpressure: none.
module pre_i_sobel3x3
   import pre_i_pkg::*;
(
   input  logic [8:0][7:0] i_win,   // index 3*row+col, row 0 is the upper row
   output grad_t           o_gx,
   output grad_t           o_gy
);

   grad_t w_p [9];

   // Zero-extend each pixel into the signed result width; +/-1020 fits exactly.
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         w_p[k] = $signed({{(GRAD_W-8){1'b0}}, i_win[k]});
      end
   end

   assign o_gx = (w_p[2] + (w_p[5] <<< 1) + w_p[8])
               - (w_p[0] + (w_p[3] <<< 1) + w_p[6]);

   assign o_gy = (w_p[6] + (w_p[7] <<< 1) + w_p[8])
               - (w_p[0] + (w_p[1] <<< 1) + w_p[2]);

endmodule

// File: rtl/pre_i_gradient_gen.sv
// Loads a CTU as 64 8x8 blocks into a ping-pong store and emits interior Sobel gradients per 40-cycle slot.
// Latency: position i of a block appears at cnt=2+i of its slot, one register after the window read.
// Backpressure: pix_ready drops while the target bank is full; a slot stalls at cnt=0 until its bank is full.
module pre_i_gradient_gen
   import pre_i_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   output logic                busy,
   output logic                done,
   pre_i_gradient_gen_if.slave bus
);

   // Ping-pong store: block b lives in bank b[0], one 64-bit word per image row.
   logic [ROW_W-1:0] r_bank [2][8];
   logic [1:0]       r_full;
   logic [2:0]       r_row;
   logic [BLK_W-1:0] r_lblk;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [BLK_W-1:0] r_blk;
   logic             r_busy;
   logic             r_done;
   logic             r_cr1;
   logic             r_cr2;
   grad_t            r_gx;
   grad_t            r_gy;
   logic [2:0]       r_pr;      // interior row of the window being read, 1..6
   logic [2:0]       r_pc;      // interior column of the window being read, 1..6

   logic             w_tgt;
   logic             w_cons;
   logic             w_ready;
   logic             w_xfer;
   logic             w_free;
   logic [ROW_W-1:0] w_rm;
   logic [ROW_W-1:0] w_r0;
   logic [ROW_W-1:0] w_rp;
   logic [5:0]       w_cb;
   logic [8:0][7:0]  w_win;
   grad_t            w_gx;
   grad_t            w_gy;

   assign w_tgt   = r_lblk[0];
   assign w_cons  = r_blk[0];
   // Built only from registered state, so a bank freed at cnt=39 is writable from the next cycle.
   assign w_ready = r_busy && !r_full[w_tgt] && (r_lblk < BLK_END);
   assign w_xfer  = bus.pix_valid && w_ready;
   assign w_free  = (r_state == RUN) && (r_cnt == CNT_LAST);

   // Load bookkeeping: row/block counters and per-bank full flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_row  <= '0;
         r_lblk <= '0;
         r_full <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_row  <= '0;
         r_lblk <= '0;
         r_full <= '0;
      end else begin
         // The freed bank is never the load target in the same cycle.
         if (w_free) begin
            r_full[w_cons] <= 1'b0;
         end
         if (w_xfer) begin
            r_row <= r_row + 3'd1;
            if (r_row == 3'd7) begin
               r_full[w_tgt] <= 1'b1;
               r_lblk        <= r_lblk + 7'd1;
            end
         end
      end
   end

   // Pixel words; only read while their full flag is set, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_bank[w_tgt][r_row] <= bus.pix_row;
      end
   end

   // Select the 3x3 window around (r_pr, r_pc) from the bank being consumed.
   always_comb begin
      w_rm = r_bank[w_cons][r_pr - 3'd1];
      w_r0 = r_bank[w_cons][r_pr];
      w_rp = r_bank[w_cons][r_pr + 3'd1];
      w_cb = {r_pc - 3'd1, 3'b000};
      w_win[0] = w_rm[w_cb         +: 8];
      w_win[1] = w_rm[w_cb + 6'd8  +: 8];
      w_win[2] = w_rm[w_cb + 6'd16 +: 8];
      w_win[3] = w_r0[w_cb         +: 8];
      w_win[4] = w_r0[w_cb + 6'd8  +: 8];
      w_win[5] = w_r0[w_cb + 6'd16 +: 8];
      w_win[6] = w_rp[w_cb         +: 8];
      w_win[7] = w_rp[w_cb + 6'd8  +: 8];
      w_win[8] = w_rp[w_cb + 6'd16 +: 8];
   end

   pre_i_sobel3x3 u_sobel (
      .i_win (w_win),
      .o_gx  (w_gx),
      .o_gy  (w_gy)
   );

   // Slot sequencer with registered gradients and timing outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_blk   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cr1   <= 1'b0;
         r_cr2   <= 1'b0;
         r_gx    <= '0;
         r_gy    <= '0;
         r_pr    <= 3'd1;
         r_pc    <= 3'd1;
      end else begin
         r_done <= 1'b0;
         r_cr1  <= 1'b0;
         r_cr2  <= r_cr1;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= WAIT;
                  r_blk   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            WAIT: begin
               // Stalls sit at cnt=0, where the consumer does nothing.
               if (r_full[w_cons]) begin
                  r_state <= RUN;
                  r_cnt   <= 6'd1;
                  r_pr    <= 3'd1;
                  r_pc    <= 3'd1;
               end
            end
            RUN: begin
               if ((r_cnt >= EMIT_FIRST) && (r_cnt <= EMIT_LAST)) begin
                  r_gx  <= w_gx;
                  r_gy  <= w_gy;
                  r_cr1 <= 1'b1;
                  if (r_pc == 3'd6) begin
                     r_pc <= 3'd1;
                     r_pr <= r_pr + 3'd1;
                  end else begin
                     r_pc <= r_pc + 3'd1;
                  end
               end
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_blk   <= r_blk + 7'd1;
                  r_state <= (r_blk == BLK_LAST) ? FLUSH : WAIT;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            FLUSH: begin
               if (r_cnt == CNT_LAST) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  r_blk   <= '0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.pix_ready   = w_ready;
   assign bus.gx          = r_gx;
   assign bus.gy          = r_gy;
   assign bus.counterrun1 = r_cr1;
   assign bus.counterrun2 = r_cr2;
   assign bus.cnt         = r_cnt;
   assign bus.blockcnt    = r_blk;
   assign busy            = r_busy;
   assign done            = r_done;

endmodule

// File: tb/tb_pre_i_gradient_gen.sv
// Bench for pre_i_gradient_gen: directed CTU patterns, load hold, continuous valid, mid-CTU start and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_pre_i_gradient_gen;
   import pre_i_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   logic start;
   logic busy;
   logic done;

   pre_i_gradient_gen_if bus ();

   pre_i_gradient_gen dut (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Shared between stimulus and monitor.
   int cur_pat = 0;
   bit abort;
   bit ctu_over;
   int n_acc;
   int n_extra;

   // Monitor state, cleared whenever busy rises.
   int cyc = 0;
   bit prev_busy = 1'b0;
   bit prev_cr1 = 1'b0;
   int prev_blk = 0;
   int k = 0;
   int n_valid = 0;
   int n_bad_g = 0;
   int n_bad_cnt = 0;
   int n_bad_cr2 = 0;
   int n_bad_step = 0;
   int max_blk = 0;
   int n_done = 0;
   int first_run = -1;
   int done_cyc = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pattern 0: flat 0x80; 1: column ramp 16c; 2: row ramp 16r; 3: columns 0..3 = 255, 4..7 = 0.
   function automatic logic [63:0] row_of(input int pat, input int r);
      logic [63:0] v;
      logic [7:0]  p;
      v = '0;
      for (int c = 0; c < 8; c++) begin
         case (pat)
            0:       p = 8'h80;
            1:       p = 8'(16 * c);
            2:       p = 8'(16 * r);
            default: p = (c < 4) ? 8'hFF : 8'h00;
         endcase
         v[8*c +: 8] = p;
      end
      return v;
   endfunction

   // Hand-derived Sobel results for the patterns above, per interior column.
   function automatic int exp_gx(input int pat, input int c);
      case (pat)
         1:       return 128;
         3:       return ((c == 3) || (c == 4)) ? -1020 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_gy(input int pat);
      return (pat == 2) ? 128 : 0;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!prev_busy && busy) begin
         k = 0; n_valid = 0; n_bad_g = 0; n_bad_cnt = 0; n_bad_cr2 = 0;
         n_bad_step = 0; max_blk = 0; n_done = 0; first_run = -1; prev_blk = 0;
      end
      if (busy && first_run < 0 && bus.cnt == 6'd1 && bus.blockcnt == 7'd0)
         first_run = cyc;
      if (bus.counterrun1) begin
         n_valid++;
         if (int'(bus.cnt) != 2 + k) n_bad_cnt++;
         if (int'($signed(bus.gx)) != exp_gx(cur_pat, 1 + k % 6) ||
             int'($signed(bus.gy)) != exp_gy(cur_pat)) n_bad_g++;
         k = (k == 35) ? 0 : k + 1;
      end
      if (bus.counterrun2 != prev_cr1) n_bad_cr2++;
      if (busy) begin
         if (int'(bus.blockcnt) != prev_blk && int'(bus.blockcnt) != prev_blk + 1) n_bad_step++;
         if (int'(bus.blockcnt) > max_blk) max_blk = int'(bus.blockcnt);
         prev_blk = int'(bus.blockcnt);
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      prev_cr1  = bus.counterrun1;
      prev_busy = busy;
   end

   task automatic check_zero(input string p);
      check_val({p, "_gx"},       int'($signed(bus.gx)), 0);
      check_val({p, "_gy"},       int'($signed(bus.gy)), 0);
      check_val({p, "_cr1"},      int'(bus.counterrun1), 0);
      check_val({p, "_cr2"},      int'(bus.counterrun2), 0);
      check_val({p, "_cnt"},      int'(bus.cnt), 0);
      check_val({p, "_blockcnt"}, int'(bus.blockcnt), 0);
      check_val({p, "_busy"},     int'(busy), 0);
      check_val({p, "_done"},     int'(done), 0);
      check_val({p, "_ready"},    int'(bus.pix_ready), 0);
   endtask

   task automatic loader(input int pat, input int hold_blk, input bit keep);
      int to;
      int n_hold_bad;
      for (int b = 0; b < 64 && !abort && !ctu_over; b++) begin
         for (int r = 0; r < 8 && !abort && !ctu_over; r++) begin
            if (b == hold_blk && r == 7) begin
               bus.pix_valid = 1'b0;
               n_hold_bad = 0;
               for (int h = 0; h < 100; h++) begin
                  @(negedge clk);
                  if (h >= 50 && (bus.cnt != 6'd0 || bus.blockcnt != 7'(hold_blk) ||
                                  bus.counterrun1 || bus.counterrun2)) n_hold_bad++;
               end
               check_val("hold_bad_cycles", n_hold_bad, 0);
               check_val("hold_cnt", int'(bus.cnt), 0);
               check_val("hold_blockcnt", int'(bus.blockcnt), hold_blk);
            end
            bus.pix_valid = 1'b1;
            bus.pix_row   = row_of(pat, r);
            to = 0;
            while (!bus.pix_ready && !abort && !ctu_over && to < 5000) begin
               @(negedge clk);
               to++;
            end
            if (abort || ctu_over) break;
            if (!bus.pix_ready) begin
               check_val("load_ready_timeout", int'(bus.pix_ready), 1);
               bus.pix_valid = 1'b0;
               return;
            end
            @(negedge clk);
            n_acc++;
         end
      end
      if (keep) begin
         while (!ctu_over && !abort) begin
            @(negedge clk);
            if (bus.pix_ready) n_extra++;
         end
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic watcher(input bit mid, input bit chk, input bit rst_at);
      int t;
      t = 0;
      while (!done && t < 6000) begin
         @(negedge clk);
         t++;
         if (rst_at && bus.blockcnt == 7'd30 && bus.cnt == 6'd20) begin
            rstn = 1'b0;
            #1;
            check_zero("midrst");
            abort = 1'b1;
            break;
         end
         if (mid && bus.blockcnt == 7'd10 && bus.cnt == 6'd5) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         if (chk && busy && bus.blockcnt == 7'd0 && bus.cnt == 6'd20)
            check_val("both_full_ready", int'(bus.pix_ready), 0);
      end
      if (!rst_at) check_val("done_seen", int'(done), 1);
      ctu_over = 1'b1;
   endtask

   task automatic run_ctu(input int pat, input int hold_blk, input bit keep, input bit mid, input bit rst_at);
      cur_pat = pat; abort = 1'b0; ctu_over = 1'b0; n_acc = 0; n_extra = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("ready_after_start", int'(bus.pix_ready), 1);
      fork
         loader(pat, hold_blk, keep);
         watcher(mid, keep, rst_at);
      join
      if (!rst_at) begin
         check_val("rows_accepted", n_acc, 512);
         if (keep) check_val("extra_xfers", n_extra, 0);
      end
      bus.pix_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic post_checks(input bit stalled);
      int iv;
      check_val("valid_samples", n_valid, 2304);
      check_val("grad_bad", n_bad_g, 0);
      check_val("cnt_at_valid_bad", n_bad_cnt, 0);
      check_val("cr2_bad", n_bad_cr2, 0);
      check_val("blk_step_bad", n_bad_step, 0);
      check_val("blk_max", max_blk, 64);
      check_val("done_pulses", n_done, 1);
      iv = done_cyc - first_run;
      if (!stalled) check_val("done_interval", iv, 2599);
      else check_val("done_interval_stall", (iv >= 2649 && iv <= 2699) ? 2649 : iv, 2649);
   endtask

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_row   = '0;
      start         = 1'b0;
      rstn          = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("rst");
      rstn = 1'b1;
      @(negedge clk);
      check_val("idle_ready", int'(bus.pix_ready), 0);

      run_ctu(0, -1, 1'b1, 1'b1, 1'b0);
      post_checks(1'b0);
      run_ctu(1, -1, 1'b0, 1'b0, 1'b0);
      post_checks(1'b0);
      run_ctu(2, -1, 1'b0, 1'b0, 1'b0);
      post_checks(1'b0);
      run_ctu(3, 5, 1'b0, 1'b0, 1'b0);
      post_checks(1'b1);

      run_ctu(1, -1, 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (50) @(negedge clk);
      check_val("rst_no_done", n_done, 0);
      check_val("rst_idle_busy", int'(busy), 0);
      run_ctu(2, -1, 1'b0, 1'b0, 1'b0);
      post_checks(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
